// File: rtl/serial_word_scheduler.sv
// Round-robin scheduler that shares one serial bit-stream detector between requesters:
// shifts each granted word MSB-first, captures the detector result, then clears it.
module serial_word_scheduler #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] word_i,
  output logic [N_REQ-1:0]        grant,
  output logic                    b_o,
  output logic                    clr_o,
  input  logic [2:0]              det_y,
  input  logic [3:0]              det_n,
  input  logic [3:0]              det_s,
  output logic                    res_valid,
  output logic [1:0]              res_id,
  output logic [2:0]              res_y,
  output logic [3:0]              res_n,
  output logic [3:0]              res_s,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_SETTLE,
    S_CAPTURE,
    S_CLEAR
  } state_t;

  localparam logic [4:0] CNT_INIT = 5'(WORD_W - 1);
  localparam logic [7:0] GAP_INIT = 8'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);

  state_t              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [7:0]          gap_q, gap_d;
  logic [1:0]          cur_id_q, cur_id_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                b_q, b_d;
  logic                clr_q, clr_d;
  logic                res_valid_q, res_valid_d;
  logic [1:0]          res_id_q, res_id_d;
  logic [2:0]          res_y_q, res_y_d;
  logic [3:0]          res_n_q, res_n_d;
  logic [3:0]          res_s_q, res_s_d;
  logic                busy_q, busy_d;

  logic [WORD_W-1:0]   words [N_REQ];
  logic                found;
  logic [1:0]          pick;
  logic [1:0]          cand;
  logic [N_REQ-1:0]    pick_oh;

  // First requester at or after rr_ptr, searched circularly.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    cand    = '0;
    pick_oh = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      words[k] = word_i[k*WORD_W +: WORD_W];
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 2'((32'(rr_ptr_q) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pick_oh[k] = found && (32'(pick) == k);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    cur_id_d    = cur_id_q;
    grant_d     = '0;
    b_d         = 1'b0;
    clr_d       = 1'b1;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_y_d     = res_y_q;
    res_n_d     = res_n_q;
    res_s_d     = res_s_q;
    busy_d      = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d  = pick_oh;
          shift_d  = words[pick];
          cur_id_d = pick;
          rr_ptr_d = 2'((32'(pick) + 1) % N_REQ);
          cnt_d    = CNT_INIT;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        b_d     = shift_q[WORD_W-1];
        shift_d = {shift_q[WORD_W-2:0], 1'b0};
        clr_d   = 1'b0;
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_SETTLE: begin
        clr_d   = 1'b0;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_valid_d = 1'b1;
        res_id_d    = cur_id_q;
        res_y_d     = det_y;
        res_n_d     = det_n;
        res_s_d     = det_s;
        // The capture cycle already counts as the first clear cycle.
        if (GAP_CYC > 1) begin
          gap_d   = GAP_INIT;
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      cur_id_q    <= '0;
      grant_q     <= '0;
      b_q         <= 1'b0;
      clr_q       <= 1'b1;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_y_q     <= '0;
      res_n_q     <= '0;
      res_s_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      cur_id_q    <= cur_id_d;
      grant_q     <= grant_d;
      b_q         <= b_d;
      clr_q       <= clr_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_y_q     <= res_y_d;
      res_n_q     <= res_n_d;
      res_s_q     <= res_s_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign b_o       = b_q;
  assign clr_o     = clr_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_y     = res_y_q;
  assign res_n     = res_n_q;
  assign res_s     = res_s_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_word_scheduler.sv
// Bench for serial_word_scheduler: timeline reference model plus a clocked detector
// model, directed scenarios and randomized requester traffic.
`timescale 1ns/1ps
module tb_serial_word_scheduler;

  localparam int WORD_W  = 32;
  localparam int N_REQ   = 4;
  localparam int GAP_CYC = 2;
  localparam int IDLE_T  = 34 + GAP_CYC;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] word_i;
  logic [3:0]   grant;
  logic         b_o, clr_o;
  logic [2:0]   det_y;
  logic [3:0]   det_n, det_s;
  logic         res_valid;
  logic [1:0]   res_id;
  logic [2:0]   res_y;
  logic [3:0]   res_n, res_s;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int grant_cnt [4] = '{0, 0, 0, 0};
  int res_cnt [4] = '{0, 0, 0, 0};

  serial_word_scheduler #(
    .WORD_W (WORD_W),
    .N_REQ  (N_REQ),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .word_i   (word_i),
    .grant    (grant),
    .b_o      (b_o),
    .clr_o    (clr_o),
    .det_y    (det_y),
    .det_n    (det_n),
    .det_s    (det_s),
    .res_valid(res_valid),
    .res_id   (res_id),
    .res_y    (res_y),
    .res_n    (res_n),
    .res_s    (res_s),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Detector stand-in: y counts overlapping 101 patterns (saturating), n counts ones, s keeps the last 4 bits.
  always @(posedge clk) begin
    if (clr_o) begin
      det_y <= '0;
      det_n <= '0;
      det_s <= '0;
    end else begin
      det_s <= {det_s[2:0], b_o};
      det_n <= det_n + {3'b000, b_o};
      if ({det_s[1:0], b_o} == 3'b101 && det_y != 3'd7) det_y <= det_y + 3'd1;
    end
  end

  function automatic logic [10:0] det_ref(input logic [31:0] w);
    int unsigned ones;
    int unsigned pat;
    ones = 0;
    pat  = 0;
    for (int i = 31; i >= 0; i--) begin
      if (w[i]) ones++;
      if (i <= 29 && w[i+2] && !w[i+1] && w[i]) pat++;
    end
    if (pat > 7) pat = 7;
    return {3'(pat), 4'(ones % 16), w[3:0]};
  endfunction

  // Reference: t = cycles since the latest grant; every output is a function of t.
  int          t = IDLE_T;
  int          m_k = 0;
  logic [31:0] m_word = '0;
  int          m_rr = 0;
  logic [12:0] e_res = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t     = IDLE_T;
      m_rr  = 0;
      e_res = '0;
    end else begin
      if (t + 1 >= IDLE_T) begin
        t = IDLE_T;
        for (int i = 0; i < N_REQ; i++) begin
          if (t == IDLE_T && req[(m_rr + i) % N_REQ]) begin
            m_k    = (m_rr + i) % N_REQ;
            m_word = word_i[m_k*32 +: 32];
            m_rr   = (m_k + 1) % N_REQ;
            t      = 0;
          end
        end
      end else begin
        t = t + 1;
      end
      if (t == 34) e_res = {2'(m_k), det_ref(m_word)};
    end
  end

  always @(negedge clk) begin
    chk("grant",     grant,     (t == 0) ? (64'd1 << m_k) : 64'd0);
    chk("b_o",       b_o,       (t >= 1 && t <= 32) ? m_word[32 - t] : 1'b0);
    chk("clr_o",     clr_o,     !(t >= 1 && t <= 33));
    chk("busy",      busy,      (t >= 1 && t <= 33 + GAP_CYC));
    chk("res_valid", res_valid, (t == 34));
    chk("res_regs",  {res_id, res_y, res_n, res_s}, e_res);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (grant[k]) grant_cnt[k]++;
    if (res_valid) res_cnt[res_id]++;
  end

  task automatic wait_grant(input int max_cyc, output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (grant != 4'b0000) begin
        for (int k = 3; k >= 0; k--) if (grant[k]) idx = k;
        cyc = cyc_cnt;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout: no grant within %0d cycles (t=%0t)", max_cyc, $time);
  endtask

  int gi, gc, prev_gc, nlow, g1_before, r0_before, r1_before;
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst    = 1'b0;
    req    = '0;
    word_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_clr",   clr_o, 1'b1);
    chk("rst_b",     b_o, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_res",   {res_valid, res_id, res_y, res_n, res_s}, 14'd0);
    chk("ref_pin",   det_ref(32'h43252296), {3'd3, 4'd12, 4'd6});
    rst = 1'b1;

    // Round-robin with all requesters held
    word_i = {32'hDB1A6351, 32'h988DCDA5, 32'h5594AADC, 32'h7F9F787F};
    req    = 4'b1111;
    prev_gc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(200, gi, gc);
      chk("rr_order", gi, rr_exp[n]);
      if (n > 0) chk("rr_spacing", gc - prev_gc, 36);
      prev_gc = gc;
    end
    req = '0;
    for (int k = 0; k < 4; k++) chk("rr_res_count", res_cnt[k], (k == 0) ? 1 : 1);
    repeat (40) @(negedge clk);
    chk("rr_res_id0_count", res_cnt[0], 2);

    // Bit order
    word_i[31:0] = 32'h80000001;
    req = 4'b0001;
    wait_grant(200, gi, gc);
    req = '0;
    chk("bo_grant", grant, 4'b0001);
    nlow = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 || c == 32) chk("bo_bit_one", b_o, 1'b1);
      else if (c <= 31)      chk("bo_bit_zero", b_o, 1'b0);
      if (!clr_o) nlow++;
    end
    chk("bo_clr_low_cycles", nlow, 33);

    // Result capture
    word_i[31:0] = 32'h43252296;
    req = 4'b0001;
    wait_grant(200, gi, gc);
    req = '0;
    repeat (33) @(negedge clk);
    chk("cap_det_model", {det_y, det_n, det_s}, {3'd3, 4'd12, 4'd6});
    @(negedge clk);
    chk("cap_valid", res_valid, 1'b1);
    chk("cap_res", {res_id, res_y, res_n, res_s}, {2'd0, 3'd3, 4'd12, 4'd6});
    @(negedge clk);
    chk("cap_pulse_end", res_valid, 1'b0);

    // Fairness: req0 held, req2 arrives mid-shift
    word_i[31:0] = $urandom;
    req = 4'b0001;
    wait_grant(200, gi, gc);
    chk("fair_first", gi, 0);
    repeat (10) @(negedge clk);
    word_i[95:64] = $urandom;
    req = 4'b0101;
    wait_grant(200, gi, gc);
    chk("fair_second", gi, 2);
    req[2] = 1'b0;
    wait_grant(200, gi, gc);
    chk("fair_third", gi, 0);
    req = 4'b0001;

    // Withdrawal: req1 pulsed only while busy
    wait_grant(200, gi, gc);
    chk("wd_first", gi, 0);
    g1_before = grant_cnt[1];
    r0_before = res_cnt[0];
    r1_before = res_cnt[1];
    repeat (5) @(negedge clk);
    word_i[63:32] = $urandom;
    req[1] = 1'b1;
    repeat (15) @(negedge clk);
    req[1] = 1'b0;
    wait_grant(200, gi, gc);
    chk("wd_second", gi, 0);
    req = '0;
    repeat (40) @(negedge clk);
    chk("wd_no_grant1", grant_cnt[1] - g1_before, 0);
    chk("wd_no_res1", res_cnt[1] - r1_before, 0);
    chk("wd_res0", res_cnt[0] - r0_before, 2);

    // Reset in the middle of a word
    word_i[31:0] = 32'hFFFF0000;
    req = 4'b0001;
    wait_grant(200, gi, gc);
    req = '0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_b", b_o, 1'b0);
    chk("mid_rst_clr", clr_o, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_res", {res_valid, res_id, res_y, res_n, res_s}, 14'd0);
    word_i = {$urandom, $urandom, $urandom, $urandom};
    req = 4'b1111;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    wait_grant(200, gi, gc);
    chk("mid_rst_first_grant", gi, 0);
    repeat (2) @(negedge clk);
    req = '0;

    // Randomized requester traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (grant[k]) begin
          if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
          else word_i[k*32 +: 32] = $urandom;
        end else if (!req[k] && $urandom_range(0, 15) == 0) begin
          word_i[k*32 +: 32] = $urandom;
          req[k] = 1'b1;
        end else if (req[k] && $urandom_range(0, 199) == 0) begin
          req[k] = 1'b0;
        end
      end
    end
    req = '0;
    repeat (50) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_scheduler.md
# serial_word_scheduler

Round-robin controller that shares the team's serial bit-stream detector between up to four requesters. Each requester offers one 32-bit word. The scheduler grants one word at a time and shifts it MSB-first onto the detector's serial input. It then captures the detector's y/n/s result and tags it with the requester index, and holds the detector in clear between words. It replaces the hand-sequenced bit feeding and clearing currently done around the detector.

## Interface
- `WORD_W`, 32, bits per word; shift count.
- `N_REQ`, 4, number of requesters; the index width is fixed at 2 bits.
- `GAP_CYC`, 2, detector-clear cycles between words; minimum 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester word-available flags.
- `word_i`  in  N_REQ*WORD_W  requester k's word in bits [k*WORD_W +: WORD_W].
- `grant`  out  N_REQ  one-hot, one-cycle pulse: word k accepted.
- `b_o`  out  1  serial bit to the detector's `b`.
- `clr_o`  out  1  active-high clear to the detector's `rst`.
- `det_y` `det_n` `det_s`  in  3/4/4  detector outputs.
- `res_valid`  out  1  one-cycle pulse: result registers updated.
- `res_id`  out  2  requester index of the result.
- `res_y` `res_n` `res_s`  out  3/4/4  captured detector outputs.
- `busy`  out  1  high while a word is in flight (SHIFT, SETTLE, CAPTURE, CLEAR).

## Operation
- All outputs are registered.
- Reset values: grant=0, b_o=0, clr_o=1, res_valid=0, res_id=0, res_y/n/s=0, busy=0, state=IDLE, rr_ptr=0.
- IDLE: clr_o=1, b_o=0.
  - If any req is high, select the first index k at or after rr_ptr, circularly.
  - Pulse grant[k], latch word_i slice k into the shift register and k into cur_id.
  - Set rr_ptr=(k+1) mod N_REQ and go to SHIFT. Otherwise stay in IDLE.
- SHIFT: clr_o=0.
  - b_o = shift_reg[WORD_W-1]; shift left one position per cycle.
  - Runs exactly WORD_W cycles, counted by a 5-bit down-counter from WORD_W-1, then goes to SETTLE.
- SETTLE: one cycle; b_o=0, clr_o=0. Lets the detector register the last bit.
- CAPTURE: one cycle.
  - Sample det_y/n/s into res_y/n/s and cur_id into res_id.
  - Pulse res_valid, set clr_o=1, go to CLEAR.
- CLEAR: clr_o=1 for GAP_CYC cycles total, counting the CAPTURE cycle as the first. Then go to IDLE.
- Requester contract:
  - Hold req and word_i stable until grant.
  - The word is consumed on grant; deasserting req before grant withdraws it, with no transfer.
  - A requester holding req high across grants is served again only after every other active requester has been served once.
- req changes while busy are ignored; arbitration happens only in IDLE.
- Reset asserted mid-word aborts immediately to the reset values. No partial result is produced and res_* is cleared.

## Timing
- Grant in IDLE cycle g; b_o carries bit 31 in cycle g+1 through bit 0 in cycle g+32.
- SETTLE is cycle g+33.
- res_* is sampled at the edge ending g+33; res_valid is high in cycle g+34 only, with res_* stable from g+34 until the next CAPTURE.
- clr_o is low from g+1 through g+33 and high from g+34.
- IDLE is re-entered at g+34+GAP_CYC; the earliest next grant is in that cycle.
- With the default GAP_CYC=2: period of 36 cycles per word when back-to-back.
- busy is high g+1 through g+33+GAP_CYC.
- Reset deassertion is asynchronous. The first grant is possible in the first clock cycle after rst goes high.

## Test plan
- Bit order:
  - Stimulus: req=0001, word0=0x80000001.
  - Required: grant=0001 at g; b_o=1 at g+1; b_o=0 for g+2..g+31; b_o=1 at g+32; clr_o low for exactly 33 cycles.
- Result capture:
  - Stimulus: word0=0x43252296, with a behavioural detector model driving det_* (check its output at g+33).
  - Required: res_valid pulse at g+34 with res_id=0 and res_y/n/s equal to the det_* values sampled at the g+33 edge.
- Round-robin:
  - Stimulus: req=1111 held, words 0x7F9F787F / 0x5594AADC / 0x988DCDA5 / 0xDB1A6351.
  - Required: grants 0,1,2,3,0 in order, spaced 36 cycles apart; res_id follows the same sequence.
- Fairness:
  - Stimulus: req0 held high, req2 raised mid-SHIFT of word 0.
  - Required: the next grant goes to 2, then back to 0.
- Withdrawal:
  - Stimulus: req1 pulsed while busy and dropped before IDLE.
  - Required: no grant[1], no result with res_id=1.
- Reset mid-operation:
  - Stimulus: rst low at g+15.
  - Required: b_o=0, clr_o=1, busy=0, res_*=0 asynchronously; no res_valid; after release the first grant goes to requester 0 (rr_ptr=0).
